// File: rtl/regfile_mp.sv
// Multi-port register file: one write port, two registered read ports with
// write-to-read bypass, optional hardwired-zero entry 0, a sequential
// bulk-clear engine and a registered LED field taken from read port A.
module regfile_mp #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned LED_W    = 8,
    parameter int unsigned SEL_W    = 2,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Write_Reg,
    input  logic [ADDR_W-1:0] W_Addr,
    input  logic [DATA_W-1:0] W_Data,
    input  logic              Read_Reg,
    input  logic [ADDR_W-1:0] R_Addr_A,
    input  logic [ADDR_W-1:0] R_Addr_B,
    output logic [DATA_W-1:0] Rd_Data_A,
    output logic [DATA_W-1:0] Rd_Data_B,
    input  logic [SEL_W-1:0]  choose,
    output logic [LED_W-1:0]  LED,
    input  logic              Clear,
    output logic              Busy
);

    localparam int unsigned DEPTH  = 2 ** ADDR_W;
    localparam int unsigned IDX_W  = ADDR_W + 1;
    localparam int unsigned NFIELD = 2 ** SEL_W;

    // The LED field slicing only makes sense when the fields tile the word exactly.
    if (DATA_W != LED_W * NFIELD) begin : g_cfg_check
        $error("regfile_mp: DATA_W must equal LED_W * 2**SEL_W");
    end

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               busy_q, busy_d;
    logic               clr_en;
    logic               wr_eff;

    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic [DATA_W-1:0]  rd_a_q, rd_a_d;
    logic [DATA_W-1:0]  rd_b_q, rd_b_d;
    logic [LED_W-1:0]   led_q, led_d;

    // Write is accepted only when idle and not aimed at a hardwired-zero entry 0.
    always_comb begin
        wr_eff = Write_Reg && (state_q == ST_IDLE)
                 && !(ZERO_REG && (W_Addr == '0));
    end

    // Clear FSM: next state, clear index and busy flag.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        clr_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Clear) begin
                    state_d = ST_CLEAR;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            ST_CLEAR: begin
                clr_en = 1'b1;
                if (idx_q == IDX_W'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    busy_d  = 1'b0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
        end
    end

    // Storage array: reset, normal writes and clear-engine writes never overlap.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (wr_eff) begin
                mem_q[W_Addr] <= W_Data;
            end
            if (clr_en) begin
                mem_q[idx_q[ADDR_W-1:0]] <= '0;
            end
        end
    end

    // Read ports: hold when not enabled, zero entry wins over bypass, bypass over array.
    always_comb begin
        rd_a_d = rd_a_q;
        rd_b_d = rd_b_q;
        if (Read_Reg) begin
            if (ZERO_REG && (R_Addr_A == '0)) begin
                rd_a_d = '0;
            end else if (wr_eff && (W_Addr == R_Addr_A)) begin
                rd_a_d = W_Data;
            end else begin
                rd_a_d = mem_q[R_Addr_A];
            end
            if (ZERO_REG && (R_Addr_B == '0)) begin
                rd_b_d = '0;
            end else if (wr_eff && (W_Addr == R_Addr_B)) begin
                rd_b_d = W_Data;
            end else begin
                rd_b_d = mem_q[R_Addr_B];
            end
        end
    end

    // LED field select from the registered port-A data.
    always_comb begin
        led_d = '0;
        for (int unsigned i = 0; i < NFIELD; i++) begin
            if (choose == SEL_W'(i)) begin
                led_d = rd_a_q[i*LED_W +: LED_W];
            end
        end
    end

    // Output registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rd_a_q <= '0;
            rd_b_q <= '0;
            led_q  <= '0;
        end else begin
            rd_a_q <= rd_a_d;
            rd_b_q <= rd_b_d;
            led_q  <= led_d;
        end
    end

    assign Rd_Data_A = rd_a_q;
    assign Rd_Data_B = rd_b_q;
    assign LED       = led_q;
    assign Busy      = busy_q;

endmodule
